// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data SRAM port arbiter:
// owner encodings, default starvation bound and byte-enable width helper.
package mem_port_arbiter_pkg;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  localparam int MAX_STREAK_DEF = 4;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_streak.sv
// Saturating count of consecutive data grants taken while a fetch waits;
// sat_o tells the arbiter the fetch must win the next contested cycle.
module arb_streak_counter #(
  parameter int MAX_STREAK = 4,
  parameter int STREAK_W   = 3
) (
  input  logic clk_i,
  input  logic resetn_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  logic [STREAK_W-1:0] cnt_q;
  logic [STREAK_W-1:0] cnt_d;

  // clear wins over increment; increment stops at the bound
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {STREAK_W{1'b0}};
    end else if (inc_i && (cnt_q != STREAK_W'(MAX_STREAK))) begin
      cnt_d = cnt_q + {{(STREAK_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      cnt_q <= {STREAK_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_o = (cnt_q == STREAK_W'(MAX_STREAK));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto one single-port SRAM with a
// 1-cycle read latency; data has priority but fetch is forced through after a streak.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = MAX_STREAK_DEF,
  parameter int STREAK_W   = 3
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        inst_req,
  input  logic [ADDR_W-1:0]           inst_addr,
  input  logic                        inst_cancel,
  output logic                        inst_addr_ok,
  output logic                        inst_data_ok,
  output logic [DATA_W-1:0]           inst_rdata,
  input  logic                        data_req,
  input  logic [be_width(DATA_W)-1:0] data_wen,
  input  logic [ADDR_W-1:0]           data_addr,
  input  logic [DATA_W-1:0]           data_wdata,
  output logic                        data_addr_ok,
  output logic                        data_data_ok,
  output logic [DATA_W-1:0]           data_rdata,
  output logic                        mem_en,
  output logic [be_width(DATA_W)-1:0] mem_wen,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int BE_W = be_width(DATA_W);

  logic inst_elig;
  logic grant_inst;
  logic grant_data;
  logic streak_sat;
  logic resp_valid_q, resp_valid_d;
  logic resp_owner_q, resp_owner_d;

  // grant and memory drive; all grants are suppressed while in reset
  always_comb begin
    inst_elig    = inst_req & ~inst_cancel;
    grant_data   = resetn & data_req & ~(inst_elig & streak_sat);
    grant_inst   = resetn & inst_elig & ~grant_data;
    mem_en       = grant_inst | grant_data;
    mem_wen      = {BE_W{1'b0}};
    mem_addr     = {ADDR_W{1'b0}};
    mem_wdata    = {DATA_W{1'b0}};
    resp_valid_d = grant_inst | grant_data;
    resp_owner_d = OWNER_INST;
    if (grant_data) begin
      mem_wen      = data_wen;
      mem_addr     = data_addr;
      mem_wdata    = data_wdata;
      resp_owner_d = OWNER_DATA;
    end else if (grant_inst) begin
      mem_addr     = inst_addr;
    end else begin
      resp_owner_d = OWNER_INST;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      resp_valid_q <= 1'b0;
      resp_owner_q <= OWNER_INST;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
    end
  end

  arb_streak_counter #(
    .MAX_STREAK (MAX_STREAK),
    .STREAK_W   (STREAK_W)
  ) u_streak (
    .clk_i    (clk),
    .resetn_i (resetn),
    .inc_i    (grant_data & inst_elig),
    .clr_i    (grant_inst | ~inst_req),
    .sat_o    (streak_sat)
  );

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;
  // a redirect in the response cycle silently drops the returning fetch
  assign data_data_ok = resetn & resp_valid_q & (resp_owner_q == OWNER_DATA);
  assign inst_data_ok = resetn & resp_valid_q & (resp_owner_q == OWNER_INST) & ~inst_cancel;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

endmodule
